div_arbiter: RTL and testbench

- Round-robin controller that shares one sequential unsigned divider (Divider32bu-style: operands a/b, rst starts/restarts it, finish flags a valid q/r) between two requesters.
- Accepts operand pairs through valid/ready handshakes and pulses the divider's start/reset.
- Waits for finish, guarded by a timeout, then returns a one-cycle tagged result.
- Handles divide-by-zero locally, without using the divider.

---
 rtl/div_arbiter.sv | 112 +++++++++++
 tb/tb_div_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one sequential unsigned divider between two requesters
module div_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid0,
   input  logic [WIDTH-1:0] in_a0,
   input  logic [WIDTH-1:0] in_b0,
   output logic             in_ready0,
   input  logic             in_valid1,
   input  logic [WIDTH-1:0] in_a1,
   input  logic [WIDTH-1:0] in_b1,
   output logic             in_ready1,
   output logic             out_valid,
   output logic             out_id,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] out_r,
   output logic             out_err,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_start,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             div_finish
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] SETTLE = 3'd2;
   localparam logic [2:0] BUSY   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   logic [2:0]       state;
   logic             last;
   logic             id;
   logic [CW-1:0]    cnt;
   logic             idle;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   // grant goes to the lone requester, or to the one not served last when both ask
   always_comb begin
      idle  = ~rst & (state == IDLE);
      gnt0  = in_valid0 & (~in_valid1 | last);
      gnt1  = in_valid1 & (~in_valid0 | ~last);
      sel_a = gnt1 ? in_a1 : in_a0;
      sel_b = gnt1 ? in_b1 : in_b0;
   end
   assign in_ready0 = idle & gnt0;
   assign in_ready1 = idle & gnt1;
   assign out_valid = ~rst & (state == DONE);
   assign div_start = rst | (state == START);
   // control FSM; result registers are loaded on entry to DONE and held afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last    <= 1'b1;
         id      <= 1'b0;
         cnt     <= '0;
         out_id  <= 1'b0;
         out_q   <= '0;
         out_r   <= '0;
         out_err <= 1'b0;
         div_a   <= '0;
         div_b   <= '0;
      end else begin
         case (state)
            IDLE: if (gnt0 | gnt1) begin
               div_a <= sel_a;
               div_b <= sel_b;
               id    <= gnt1;
               if (sel_b == '0) begin
                  out_id  <= gnt1;
                  out_q   <= '1;
                  out_r   <= sel_a;
                  out_err <= 1'b1;
                  state   <= DONE;
               end else
                  state <= START;
            end
            START: state <= SETTLE;
            SETTLE: begin
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (div_finish) begin
                  out_id  <= id;
                  out_q   <= div_q;
                  out_r   <= div_r;
                  out_err <= 1'b0;
                  state   <= DONE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  out_id  <= id;
                  out_q   <= '0;
                  out_r   <= '0;
                  out_err <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               last  <= out_id;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized scoreboard bench for div_arbiter with a behavioural divider model
module tb_div_arbiter;
   localparam int TO = 8;
   logic        clk = 0;
   logic        rst = 1;
   logic        in_valid0 = 0, in_valid1 = 0;
   logic [31:0] in_a0 = 0, in_b0 = 0, in_a1 = 0, in_b1 = 0;
   logic        in_ready0, in_ready1, out_valid, out_id, out_err, div_start, div_finish;
   logic [31:0] out_q, out_r, div_a, div_b, div_q, div_r;
   int checks = 0, errors = 0, cyc = 0;
   typedef struct {logic id; logic [31:0] a, q, r; logic err; logic zero; int t, lat;} req_t;
   req_t sb[$];
   req_t e;
   logic ids[$];
   int last_start = -1, last_out = -1;
   logic prev_start = 0, prev_v = 0;
   logic [63:0] hold_v;
   int mlat = 2;
   bit hang = 0, stale = 0;
   logic [31:0] ma = 0, mb = 0, mq = 0, mr = 0;
   logic mfin = 0, marm = 0;
   int mcnt = 0;

   div_arbiter #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid0(in_valid0), .in_a0(in_a0), .in_b0(in_b0), .in_ready0(in_ready0),
      .in_valid1(in_valid1), .in_a1(in_a1), .in_b1(in_b1), .in_ready1(in_ready1),
      .out_valid(out_valid), .out_id(out_id), .out_q(out_q), .out_r(out_r), .out_err(out_err),
      .div_a(div_a), .div_b(div_b), .div_start(div_start),
      .div_q(div_q), .div_r(div_r), .div_finish(div_finish)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // divider model: restart on div_start, result mlat cycles later; stale mode keeps old finish/result
   assign div_q = mq;
   assign div_r = mr;
   assign div_finish = mfin;
   always @(posedge clk) begin
      if (div_start) begin
         ma <= div_a; mb <= div_b; mcnt <= 0; marm <= !rst;
         if (!stale) mfin <= 0;
      end else begin
         mcnt <= mcnt + 1;
         if (marm && !hang && mcnt + 1 == mlat) begin
            mq <= ma / mb; mr <= ma % mb; mfin <= 1; marm <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic req_t expect_of(input logic id, input logic [31:0] a, input logic [31:0] b, input int t);
      req_t x;
      x.id = id; x.a = a; x.t = t; x.zero = (b == 0);
      if (b == 0) begin x.q = 32'hFFFF_FFFF; x.r = a; x.err = 1; x.lat = 1; end
      else if (hang) begin x.q = 0; x.r = 0; x.err = 1; x.lat = 3 + TO; end
      else begin x.q = a / b; x.r = a % b; x.err = 0; x.lat = 3 + mlat; end
      return x;
   endfunction

   // monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 64'(out_valid), 0);
         chk("rst_start", 64'(div_start), 1);
         chk("rst_ready", 64'({in_ready0, in_ready1}), 0);
         sb.delete(); prev_v = 0; prev_start = 0;
      end else begin
         if (div_start) begin
            chk("start_width", 64'(prev_start), 0);
            last_start = cyc;
         end
         prev_start = div_start;
         if (prev_v && !out_valid) chk("hold", {out_q, out_r}, hold_v);
         if (in_ready0) sb.push_back(expect_of(0, in_a0, in_b0, cyc));
         if (in_ready1) sb.push_back(expect_of(1, in_a1, in_b1, cyc));
         if (out_valid) begin
            if (sb.size() == 0) chk("spurious_valid", 64'(out_valid), 0);
            else begin
               e = sb.pop_front();
               chk("id", 64'(out_id), 64'(e.id));
               chk("q", 64'(out_q), 64'(e.q));
               chk("r", 64'(out_r), 64'(e.r));
               chk("err", 64'(out_err), 64'(e.err));
               chk("latency", 64'(cyc - e.t), 64'(e.lat));
               if (e.zero) chk("zero_nostart", 64'(last_start > e.t), 0);
               else chk("start_cyc", 64'(last_start), 64'(e.t + 1));
               ids.push_back(out_id);
               last_out = cyc;
            end
            hold_v = {out_q, out_r};
         end
         prev_v = out_valid;
      end
   end

   task automatic req(input bit id, input logic [31:0] a, input logic [31:0] b, output int acc);
      if (id) begin in_valid1 = 1; in_a1 = a; in_b1 = b; end
      else begin in_valid0 = 1; in_a0 = a; in_b0 = b; end
      acc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (id ? in_ready1 : in_ready0) begin acc = cyc; break; end
      end
      chk("accepted", 64'(acc >= 0), 1);
      @(posedge clk); #1;
      if (id) in_valid1 = 0; else in_valid0 = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(sb.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, base;
      logic [31:0] ra, rb, sa, sbv;
      int sel;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_q", {out_q, out_r}, 0);
      chk("rst_id_err", 64'({out_id, out_err}), 0);
      chk("rst_div_ab", {div_a, div_b}, 0);
      @(posedge clk); #1;
      rst = 0;
      // single request straight out of reset
      req(0, 10, 3, a0);
      drain();
      // divide by zero on requester 1
      req(1, 5, 0, a1);
      drain();
      // simultaneous requests: 0 wins, 1 waits until the first result
      mlat = 3;
      fork
         req(0, 100, 7, a0);
         req(1, 7, 32, a1);
      join
      drain();
      chk("wait_ready1", 64'(a1), 64'(a0 + 4 + mlat));
      chk("first_id", 64'(ids[ids.size() - 2]), 0);
      // both requesters continuously valid: strict alternation
      base = ids.size();
      fork
         for (int k = 0; k < 3; k++) req(0, $urandom, $urandom_range(1, 50), a0);
         for (int k = 0; k < 3; k++) req(1, $urandom, $urandom_range(1, 50), a1);
      join
      drain();
      chk("order_cnt", 64'(ids.size() - base), 6);
      for (int k = 0; k < 6; k++) chk("order", 64'(ids[base + k]), 64'(k % 2));
      // divider never finishes, then a normal one
      hang = 1;
      req(0, 77, 5, a0);
      drain();
      hang = 0;
      req(1, 100, 7, a1);
      drain();
      // stale finish held through START/SETTLE; fresh result on first BUSY cycle
      stale = 1; mlat = 1;
      req(0, 50, 5, a0);
      drain();
      stale = 0; mlat = 2;
      // reset during BUSY drops the op and restores requester 0 priority
      hang = 1;
      req(0, 9, 2, a0);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0; hang = 0;
      base = ids.size();
      fork
         req(0, 20, 6, a0);
         req(1, 21, 4, a1);
      join
      drain();
      chk("post_rst_cnt", 64'(ids.size() - base), 2);
      chk("post_rst_first", 64'(ids[base]), 0);
      // random traffic
      for (int n = 0; n < 40; n++) begin
         mlat = $urandom_range(1, 6);
         sel = $urandom_range(1, 3);
         ra = $urandom; sa = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 0 : (($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(1, 20));
         sbv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1000);
         if (sel == 1) req(0, ra, rb, a0);
         else if (sel == 2) req(1, sa, sbv, a1);
         else fork
            req(0, ra, rb, a0);
            req(1, sa, sbv, a1);
         join
         drain();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
